// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB completer with configurable wait states, backed by a
// 32-bit register file with a read-only ID word and a read-only transfer counter.
module apb_slave_regfile #(
    parameter int          SLV_ID      = 0,
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic [2:0]  psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);
    localparam int AW = $clog2(NUM_REGS);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state_q, state_d;
    logic [11:0] cap_addr_q, cap_addr_d;
    logic        cap_write_q, cap_write_d;
    logic [31:0] cap_wdata_q, cap_wdata_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic        pready_d, pslverr_d;
    logic [31:0] prdata_d;
    logic [15:0] xfer_cnt;
    logic [31:0] regs [NUM_REGS];
    logic        commit;

    logic        sel;
    logic [11:0] src_addr;
    logic        src_write;
    logic [9:0]  src_idx;
    logic        src_err;
    logic [31:0] src_rdata;
    logic [31:0] resp_prdata;
    logic        unused;

    assign unused = ^{psel, paddr[31:12]};
    assign sel    = psel[SLV_ID];

    // In IDLE the zero-wait response must be built from the live bus, otherwise from the captured request.
    assign src_addr    = (state_q == IDLE) ? paddr[11:0] : cap_addr_q;
    assign src_write   = (state_q == IDLE) ? pwrite : cap_write_q;
    assign src_idx     = src_addr[11:2];
    assign src_err     = ({1'b0, src_idx} >= 11'(NUM_REGS)) || (src_addr[1:0] != 2'b00) ||
                         (src_write && (src_idx < 10'd2));
    assign src_rdata   = (src_idx == 10'd0) ? ID_VALUE :
                         (src_idx == 10'd1) ? {16'h0000, xfer_cnt} : regs[src_idx[AW-1:0]];
    assign resp_prdata = src_write ? prdata : (src_err ? 32'h0 : src_rdata);

    always_comb begin
        state_d     = state_q;
        cap_addr_d  = cap_addr_q;
        cap_write_d = cap_write_q;
        cap_wdata_d = cap_wdata_q;
        wcnt_d      = wcnt_q;
        pready_d    = 1'b0;
        pslverr_d   = 1'b0;
        prdata_d    = prdata;
        commit      = 1'b0;
        if (state_q == IDLE) begin
            if (sel && !penable) begin
                cap_addr_d  = paddr[11:0];
                cap_write_d = pwrite;
                cap_wdata_d = pwdata;
                wcnt_d      = 4'(WAIT_CYCLES);
                state_d     = ACCESS;
                if (WAIT_CYCLES == 0) begin
                    pready_d  = 1'b1;
                    pslverr_d = src_err;
                    prdata_d  = resp_prdata;
                end
            end
        end else if (pready) begin
            commit  = !pslverr;
            state_d = IDLE;
        end else if (sel && penable) begin
            wcnt_d = wcnt_q - 4'd1;
            if (wcnt_q == 4'd1) begin
                pready_d  = 1'b1;
                pslverr_d = src_err;
                prdata_d  = resp_prdata;
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= IDLE;
            cap_addr_q  <= '0;
            cap_write_q <= 1'b0;
            cap_wdata_q <= '0;
            wcnt_q      <= '0;
            pready      <= 1'b0;
            pslverr     <= 1'b0;
            prdata      <= '0;
            xfer_cnt    <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            state_q     <= state_d;
            cap_addr_q  <= cap_addr_d;
            cap_write_q <= cap_write_d;
            cap_wdata_q <= cap_wdata_d;
            wcnt_q      <= wcnt_d;
            pready      <= pready_d;
            pslverr     <= pslverr_d;
            prdata      <= prdata_d;
            if (commit) begin
                xfer_cnt <= xfer_cnt + 16'd1;
                if (cap_write_q) regs[cap_addr_q[AW+1:2]] <= cap_wdata_q;
            end
        end
    end
endmodule
